// File: rtl/ppu_reg_file.sv
// CPU<->PPU register file: $2000-$2007, loopy v/t/x/w, VRAM port with PPUDATA read buffer, VBLANK/NMI.
// Latency: register accesses take effect one cycle after the strobe; $2007 completes the cycle after vram_ack.
// Backpressure: cpu_rdy=0 while a VRAM op is pending; accesses then are dropped, except $2002 reads.
module ppu_reg_file #(
    parameter int VRAM_AW = 14,
    parameter int OAM_AW = 8,
    parameter logic [VRAM_AW-1:0] PAL_BASE = VRAM_AW'(14'h3F00)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_stb,
    input  logic               cs_in,
    input  logic               WE,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         cpu_data_in,
    output logic [7:0]         cpu_data_out,
    output logic               cpu_rdy,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    input  logic               vram_ack,
    output logic [OAM_AW-1:0]  oam_addr,
    output logic [7:0]         oam_wdata,
    output logic               oam_we,
    input  logic [7:0]         oam_rdata,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_overflow,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [14:0]        scroll_v,
    output logic [14:0]        scroll_t,
    output logic [2:0]         fine_x,
    output logic               nmi
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic [14:0] v;
    logic [14:0] t;
    logic        w;
    logic        vblank_flag;
    logic        req_is_rd;
    logic [7:0]  rd_buf;
    logic [7:0]  io_latch;

    logic        access;
    logic        rd_status;
    logic [7:0]  status_byte;

    assign access      = cpu_stb & ~cs_in;
    assign rd_status   = access & ~WE & (reg_addr == 3'd2);
    assign status_byte = {vblank_flag, spr0_hit, spr_overflow, io_latch[4:0]};
    assign nmi         = ctrl[7] & vblank_flag;
    assign scroll_v    = v;
    assign scroll_t    = t;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            v            <= '0;
            t            <= '0;
            w            <= 1'b0;
            fine_x       <= '0;
            vblank_flag  <= 1'b0;
            req_is_rd    <= 1'b0;
            rd_buf       <= '0;
            io_latch     <= '0;
            cpu_data_out <= '0;
            cpu_rdy      <= 1'b1;
            vram_req     <= 1'b0;
            vram_we      <= 1'b0;
            vram_addr    <= '0;
            vram_wdata   <= '0;
            oam_addr     <= '0;
            oam_wdata    <= '0;
            oam_we       <= 1'b0;
            ctrl         <= '0;
            mask         <= '0;
        end else begin
            // OAM write strobes at the current address; the increment lands afterwards.
            oam_we <= 1'b0;
            if (oam_we) oam_addr <= oam_addr + OAM_AW'(1);

            // A status read racing vblank_set suppresses the set, so the frame's flag is lost.
            if (vblank_clr)      vblank_flag <= 1'b0;
            else if (rd_status)  vblank_flag <= 1'b0;
            else if (vblank_set) vblank_flag <= 1'b1;

            if (rd_status) begin
                cpu_data_out <= status_byte;
                io_latch     <= status_byte;
                w            <= 1'b0;
            end

            if (state == S_WAIT) begin
                if (vram_ack) begin
                    state    <= S_IDLE;
                    vram_req <= 1'b0;
                    cpu_rdy  <= 1'b1;
                    v        <= v + (ctrl[2] ? 15'd32 : 15'd1);
                    rd_buf   <= vram_rdata;
                    if (req_is_rd) begin
                        if (vram_addr >= PAL_BASE) begin
                            cpu_data_out <= vram_rdata;
                            io_latch     <= vram_rdata;
                        end else begin
                            cpu_data_out <= rd_buf;
                            io_latch     <= rd_buf;
                        end
                    end
                end
            end else if (access && WE) begin
                io_latch <= cpu_data_in;
                case (reg_addr)
                    3'd0: begin
                        ctrl       <= cpu_data_in;
                        t[11:10]   <= cpu_data_in[1:0];
                    end
                    3'd1: mask <= cpu_data_in;
                    3'd3: oam_addr <= OAM_AW'(cpu_data_in);
                    3'd4: begin
                        oam_wdata <= cpu_data_in;
                        oam_we    <= 1'b1;
                    end
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= cpu_data_in[7:3];
                            fine_x <= cpu_data_in[2:0];
                        end else begin
                            t[14:12] <= cpu_data_in[2:0];
                            t[9:5]   <= cpu_data_in[7:3];
                        end
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[14]   <= 1'b0;
                            t[13:8] <= cpu_data_in[5:0];
                        end else begin
                            t[7:0]  <= cpu_data_in;
                            v       <= {t[14:8], cpu_data_in};
                        end
                        w <= ~w;
                    end
                    3'd7: begin
                        state      <= S_WAIT;
                        req_is_rd  <= 1'b0;
                        cpu_rdy    <= 1'b0;
                        vram_req   <= 1'b1;
                        vram_we    <= 1'b1;
                        vram_addr  <= v[VRAM_AW-1:0];
                        vram_wdata <= cpu_data_in;
                    end
                    default: ;
                endcase
            end else if (access) begin
                case (reg_addr)
                    3'd2: ;
                    3'd4: begin
                        cpu_data_out <= oam_rdata;
                        io_latch     <= oam_rdata;
                    end
                    3'd7: begin
                        state     <= S_WAIT;
                        req_is_rd <= 1'b1;
                        cpu_rdy   <= 1'b0;
                        vram_req  <= 1'b1;
                        vram_we   <= 1'b0;
                        vram_addr <= v[VRAM_AW-1:0];
                    end
                    default: cpu_data_out <= io_latch;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ppu_reg_file.sv
// Self-checking bench for ppu_reg_file: scroll/address registers, PPUDATA buffering, VBLANK/NMI, OAM.
// Latency: expected read bytes are queued at stimulus time and popped when cpu_data_out is valid.
// Backpressure: the bench acts as VRAM and acks each request after a short hold.
module tb_ppu_reg_file;
    logic        clk;
    logic        reset;
    logic        cpu_stb;
    logic        cs_in;
    logic        WE;
    logic [2:0]  reg_addr;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_rdy;
    logic        vram_req;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        vram_ack;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;
    logic        vblank_set;
    logic        vblank_clr;
    logic        spr0_hit;
    logic        spr_overflow;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic [14:0] scroll_v;
    logic [14:0] scroll_t;
    logic [2:0]  fine_x;
    logic        nmi;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] oam_mem [0:255];

    ppu_reg_file dut (
        .clk(clk), .reset(reset), .cpu_stb(cpu_stb), .cs_in(cs_in), .WE(WE),
        .reg_addr(reg_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_rdy(cpu_rdy), .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit(spr0_hit),
        .spr_overflow(spr_overflow), .ctrl(ctrl), .mask(mask), .scroll_v(scroll_v),
        .scroll_t(scroll_t), .fine_x(fine_x), .nmi(nmi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural OAM: preset pattern, written on the DUT's strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) oam_mem[i] <= 8'(i) ^ 8'hA5;
        end else if (oam_we) begin
            oam_mem[oam_addr] <= oam_wdata;
        end
    end
    assign oam_rdata = oam_mem[oam_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cpu_acc(input logic wr, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_stb = 1'b1; cs_in = 1'b0; WE = wr; reg_addr = a; cpu_data_in = d;
        @(negedge clk);
        cpu_stb = 1'b0; cs_in = 1'b1; WE = 1'b0;
    endtask

    task automatic pulse_vb(input logic s, input logic c);
        @(negedge clk);
        vblank_set = s; vblank_clr = c;
        @(negedge clk);
        vblank_set = 1'b0; vblank_clr = 1'b0;
    endtask

    task automatic vram_service(input logic [7:0] rd, output logic [7:0] q);
        int n;
        n = 0;
        while (vram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (vram_req !== 1'b1) begin n_err++; $display("FAIL vram_req_wait got=%b exp=1", vram_req); end
        vram_rdata = rd; vram_ack = 1'b1;
        @(negedge clk);
        vram_ack = 1'b0;
        n = 0;
        while (cpu_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL cpu_rdy_wait got=%b exp=1", cpu_rdy); end
        q = cpu_data_out;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy got=%b exp=1", cpu_rdy); end
        n_cmp++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", vram_req); end
        n_cmp++; if ({scroll_v, scroll_t, fine_x} !== 33'd0) begin n_err++; $display("FAIL rst_scroll got=%h/%h/%h exp=0", scroll_v, scroll_t, fine_x); end
        n_cmp++; if ({ctrl, mask, oam_addr, nmi, cpu_data_out} !== 33'd0) begin n_err++; $display("FAIL rst_regs got=%h/%h/%h/%b/%h exp=0", ctrl, mask, oam_addr, nmi, cpu_data_out); end
        exp_q.push_back(8'h00);
        cpu_acc(1'b0, 3'd0, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL rst_open_bus got=%h exp=%h", cpu_data_out, e); end
    endtask

    task automatic test_addr();
        logic [7:0] e;
        cpu_acc(1'b1, 3'd6, 8'h21);
        n_cmp++; if (scroll_t !== 15'h2100) begin n_err++; $display("FAIL addr_hi got=%h exp=2100", scroll_t); end
        exp_q.push_back(8'h01);
        cpu_acc(1'b0, 3'd2, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL addr_status got=%h exp=%h", cpu_data_out, e); end
        cpu_acc(1'b1, 3'd6, 8'h21);
        cpu_acc(1'b1, 3'd6, 8'h08);
        n_cmp++; if (scroll_v !== 15'h2108) begin n_err++; $display("FAIL addr_v got=%h exp=2108", scroll_v); end
        n_cmp++; if (scroll_t !== 15'h2108) begin n_err++; $display("FAIL addr_t got=%h exp=2108", scroll_t); end
    endtask

    task automatic test_vram_write();
        logic [7:0] q;
        cpu_acc(1'b1, 3'd0, 8'h04);
        n_cmp++; if (ctrl !== 8'h04) begin n_err++; $display("FAIL ctrl got=%h exp=04", ctrl); end
        cpu_acc(1'b1, 3'd7, 8'hAA);
        n_cmp++; if ({cpu_rdy, vram_req, vram_we} !== 3'b011) begin n_err++; $display("FAIL wr_req got=%b exp=011", {cpu_rdy, vram_req, vram_we}); end
        repeat (3) @(negedge clk);
        n_cmp++; if (vram_addr !== 14'h2108 || vram_wdata !== 8'hAA || vram_req !== 1'b1) begin
            n_err++; $display("FAIL wr_hold got=%h/%h/%b exp=2108/aa/1", vram_addr, vram_wdata, vram_req); end
        vram_service(8'h00, q);
        n_cmp++; if (scroll_v !== 15'h2128) begin n_err++; $display("FAIL wr_inc32 got=%h exp=2128", scroll_v); end
        n_cmp++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL wr_req_drop got=%b exp=0", vram_req); end
    endtask

    task automatic test_busy();
        logic [7:0] q;
        logic [7:0] e;
        cpu_acc(1'b1, 3'd0, 8'h00);
        cpu_acc(1'b1, 3'd7, 8'h33);
        n_cmp++; if (vram_addr !== 14'h2128) begin n_err++; $display("FAIL busy_addr got=%h exp=2128", vram_addr); end
        cpu_acc(1'b1, 3'd1, 8'hFF);
        cpu_acc(1'b1, 3'd6, 8'h3F);
        n_cmp++; if (mask !== 8'h00 || scroll_t !== 15'h2108) begin n_err++; $display("FAIL busy_ignore got=%h/%h exp=00/2108", mask, scroll_t); end
        vram_service(8'h00, q);
        n_cmp++; if (scroll_v !== 15'h2129) begin n_err++; $display("FAIL busy_inc1 got=%h exp=2129", scroll_v); end
        @(negedge clk); vram_ack = 1'b1;
        @(negedge clk); vram_ack = 1'b0;
        n_cmp++; if (scroll_v !== 15'h2129 || cpu_rdy !== 1'b1) begin n_err++; $display("FAIL idle_ack got=%h/%b exp=2129/1", scroll_v, cpu_rdy); end
        exp_q.push_back(8'h33);
        cpu_acc(1'b0, 3'd0, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL busy_latch got=%h exp=%h", cpu_data_out, e); end
    endtask

    task automatic test_read_buffer();
        logic [7:0] q;
        logic [7:0] e;
        cpu_acc(1'b1, 3'd6, 8'h20);
        cpu_acc(1'b1, 3'd6, 8'h00);
        cpu_acc(1'b0, 3'd7, 8'h00);
        n_cmp++; if (vram_we !== 1'b0 || vram_addr !== 14'h2000) begin n_err++; $display("FAIL rd1_req got=%b/%h exp=0/2000", vram_we, vram_addr); end
        exp_q.push_back(8'h00);
        vram_service(8'h11, q);
        e = exp_q.pop_front();
        n_cmp++; if (q !== e) begin n_err++; $display("FAIL rd1_data got=%h exp=%h", q, e); end
        cpu_acc(1'b0, 3'd7, 8'h00);
        n_cmp++; if (vram_addr !== 14'h2001) begin n_err++; $display("FAIL rd2_addr got=%h exp=2001", vram_addr); end
        exp_q.push_back(8'h11);
        vram_service(8'h22, q);
        e = exp_q.pop_front();
        n_cmp++; if (q !== e) begin n_err++; $display("FAIL rd2_data got=%h exp=%h", q, e); end
        n_cmp++; if (scroll_v !== 15'h2002) begin n_err++; $display("FAIL rd_v got=%h exp=2002", scroll_v); end
    endtask

    task automatic test_palette();
        logic [7:0] q;
        logic [7:0] e;
        cpu_acc(1'b1, 3'd6, 8'h3F);
        cpu_acc(1'b1, 3'd6, 8'h01);
        cpu_acc(1'b0, 3'd7, 8'h00);
        exp_q.push_back(8'h2C);
        vram_service(8'h2C, q);
        e = exp_q.pop_front();
        n_cmp++; if (q !== e) begin n_err++; $display("FAIL pal_direct got=%h exp=%h", q, e); end
        cpu_acc(1'b1, 3'd6, 8'h3E);
        cpu_acc(1'b1, 3'd6, 8'hFF);
        cpu_acc(1'b0, 3'd7, 8'h00);
        exp_q.push_back(8'h2C);
        vram_service(8'h99, q);
        e = exp_q.pop_front();
        n_cmp++; if (q !== e) begin n_err++; $display("FAIL pal_below got=%h exp=%h", q, e); end
        cpu_acc(1'b0, 3'd7, 8'h00);
        n_cmp++; if (vram_addr !== 14'h3F00) begin n_err++; $display("FAIL pal_base_addr got=%h exp=3f00", vram_addr); end
        exp_q.push_back(8'h5A);
        vram_service(8'h5A, q);
        e = exp_q.pop_front();
        n_cmp++; if (q !== e) begin n_err++; $display("FAIL pal_base got=%h exp=%h", q, e); end
    endtask

    task automatic test_vblank_nmi();
        logic [7:0] e;
        pulse_vb(1'b1, 1'b0);
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL nmi_masked got=%b exp=0", nmi); end
        cpu_acc(1'b1, 3'd0, 8'h80);
        n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL nmi_enable got=%b exp=1", nmi); end
        spr0_hit = 1'b1; spr_overflow = 1'b0;
        exp_q.push_back(8'hC0);
        cpu_acc(1'b0, 3'd2, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL status_vbl got=%h exp=%h", cpu_data_out, e); end
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL nmi_clear got=%b exp=0", nmi); end
        spr0_hit = 1'b0; spr_overflow = 1'b1;
        exp_q.push_back(8'h20);
        cpu_acc(1'b0, 3'd2, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL status_ovf got=%h exp=%h", cpu_data_out, e); end
        spr_overflow = 1'b0;
    endtask

    task automatic test_vblank_race();
        logic [7:0] e;
        @(negedge clk);
        cpu_stb = 1'b1; cs_in = 1'b0; WE = 1'b0; reg_addr = 3'd2; vblank_set = 1'b1;
        exp_q.push_back(8'h00);
        @(negedge clk);
        cpu_stb = 1'b0; cs_in = 1'b1; vblank_set = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL race_read got=%h exp=%h", cpu_data_out, e); end
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL race_nmi got=%b exp=0", nmi); end
        exp_q.push_back(8'h00);
        cpu_acc(1'b0, 3'd2, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL race_flag got=%h exp=%h", cpu_data_out, e); end
        pulse_vb(1'b1, 1'b1);
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL clr_priority got=%b exp=0", nmi); end
        pulse_vb(1'b1, 1'b0);
        n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL vbl_set got=%b exp=1", nmi); end
        pulse_vb(1'b0, 1'b1);
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL vbl_clr got=%b exp=0", nmi); end
    endtask

    task automatic test_oam();
        logic [7:0] e;
        cpu_acc(1'b1, 3'd3, 8'hFF);
        n_cmp++; if (oam_addr !== 8'hFF) begin n_err++; $display("FAIL oam_set got=%h exp=ff", oam_addr); end
        cpu_acc(1'b1, 3'd4, 8'h55);
        n_cmp++; if ({oam_we, oam_addr, oam_wdata} !== {1'b1, 8'hFF, 8'h55}) begin
            n_err++; $display("FAIL oam_pulse got=%b/%h/%h exp=1/ff/55", oam_we, oam_addr, oam_wdata); end
        @(negedge clk);
        n_cmp++; if (oam_we !== 1'b0 || oam_addr !== 8'h00) begin n_err++; $display("FAIL oam_wrap got=%b/%h exp=0/00", oam_we, oam_addr); end
        exp_q.push_back(8'hA5);
        cpu_acc(1'b0, 3'd4, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e || oam_addr !== 8'h00) begin n_err++; $display("FAIL oam_read got=%h/%h exp=%h/00", cpu_data_out, oam_addr, e); end
        cpu_acc(1'b1, 3'd3, 8'hFF);
        exp_q.push_back(8'h55);
        cpu_acc(1'b0, 3'd4, 8'h00);
        e = exp_q.pop_front();
        n_cmp++; if (cpu_data_out !== e) begin n_err++; $display("FAIL oam_readback got=%h exp=%h", cpu_data_out, e); end
    endtask

    task automatic test_scroll();
        cpu_acc(1'b1, 3'd0, 8'h00);
        cpu_acc(1'b1, 3'd6, 8'h00);
        cpu_acc(1'b1, 3'd6, 8'h00);
        cpu_acc(1'b1, 3'd5, 8'h7D);
        n_cmp++; if (scroll_t !== 15'h000F || fine_x !== 3'd5) begin n_err++; $display("FAIL scroll_x got=%h/%0d exp=000f/5", scroll_t, fine_x); end
        cpu_acc(1'b1, 3'd5, 8'h5E);
        n_cmp++; if (scroll_t !== 15'h616F || fine_x !== 3'd5 || scroll_v !== 15'h0) begin
            n_err++; $display("FAIL scroll_y got=%h/%0d/%h exp=616f/5/0000", scroll_t, fine_x, scroll_v); end
        cpu_acc(1'b1, 3'd0, 8'h03);
        n_cmp++; if (scroll_t !== 15'h6D6F) begin n_err++; $display("FAIL scroll_nt got=%h exp=6d6f", scroll_t); end
    endtask

    task automatic test_reset_mid_wait();
        cpu_acc(1'b1, 3'd7, 8'h12);
        n_cmp++; if (vram_req !== 1'b1) begin n_err++; $display("FAIL mid_req got=%b exp=1", vram_req); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (vram_req !== 1'b0 || cpu_rdy !== 1'b1) begin n_err++; $display("FAIL mid_reset got=%b/%b exp=0/1", vram_req, cpu_rdy); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (scroll_v !== 15'h0 || ctrl !== 8'h00 || vram_req !== 1'b0) begin
            n_err++; $display("FAIL post_reset got=%h/%h/%b exp=0000/00/0", scroll_v, ctrl, vram_req); end
    endtask

    initial begin
        reset = 1'b1; cpu_stb = 1'b0; cs_in = 1'b1; WE = 1'b0; reg_addr = 3'd0; cpu_data_in = 8'h00;
        vram_rdata = 8'h00; vram_ack = 1'b0; vblank_set = 1'b0; vblank_clr = 1'b0;
        spr0_hit = 1'b0; spr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_addr();
        test_vram_write();
        test_busy();
        test_read_buffer();
        test_palette();
        test_vblank_nmi();
        test_vblank_race();
        test_oam();
        test_scroll();
        test_reset_mid_wait();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
